// File: rtl/keypad_input_pkg.sv
// Shared definitions for the keypad entry block: FSM encoding, key codes and
// default scan/debounce timing.
package keypad_input_pkg;

  typedef enum logic [1:0] {
    ST_SCAN        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } state_t;

  // Digits 0-9 decode to their own value.
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  localparam int DEF_SCAN_DIV        = 1000;
  localparam int DEF_DEBOUNCE_CYCLES = 20000;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Maps a (row, column) position on the 4x4 keypad to its key code.
module keypad_decode
  import keypad_input_pkg::*;
(
  input  logic [1:0] row,
  input  logic [1:0] col,
  output logic [3:0] key_code
);

  always_comb begin
    key_code = KEY_D;
    case ({row, col})
      4'h0: key_code = 4'd1;
      4'h1: key_code = 4'd2;
      4'h2: key_code = 4'd3;
      4'h3: key_code = KEY_A;
      4'h4: key_code = 4'd4;
      4'h5: key_code = 4'd5;
      4'h6: key_code = 4'd6;
      4'h7: key_code = KEY_B;
      4'h8: key_code = 4'd7;
      4'h9: key_code = 4'd8;
      4'hA: key_code = 4'd9;
      4'hB: key_code = KEY_C;
      4'hC: key_code = KEY_STAR;
      4'hD: key_code = 4'd0;
      4'hE: key_code = KEY_HASH;
      default: key_code = KEY_D;
    endcase
  end

endmodule

// File: rtl/keypad_input.sv
// Scanned 4x4 keypad with debounce and a decimal entry accumulator; '#' commits
// the accumulated value to keyboard for the CPU, ack consumes it.
//
// state          | meaning
// ST_SCAN        | rotating column drive, waiting for any row low
// ST_DEB_PRESS   | column frozen, counting stable-low cycles on captured row
// ST_HELD        | key accepted and acted on, waiting for all rows high
// ST_DEB_RELEASE | counting stable all-high cycles before scanning again
module keypad_input
  import keypad_input_pkg::*;
#(
  parameter int SCAN_DIV        = DEF_SCAN_DIV,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_in,
  input  logic        ack,
  output logic [3:0]  col_out,
  output logic [31:0] keyboard,
  output logic        key_valid,
  output logic [3:0]  digit_count
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]    row_m, row_s;
  state_t        state, state_nxt;
  logic [SW-1:0] scan_cnt, scan_cnt_nxt;
  logic [DW-1:0] deb_cnt, deb_cnt_nxt;
  logic [1:0]    col_idx, col_idx_nxt;
  logic [1:0]    cap_row, cap_row_nxt;
  logic [1:0]    cap_col, cap_col_nxt;
  logic          apply_key;
  logic [3:0]    key_code;
  logic [31:0]   acc, acc_x10;
  logic          hash_accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_SCAN;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      col_idx  <= 2'd0;
      cap_row  <= 2'd0;
      cap_col  <= 2'd0;
    end else begin
      state    <= state_nxt;
      scan_cnt <= scan_cnt_nxt;
      deb_cnt  <= deb_cnt_nxt;
      col_idx  <= col_idx_nxt;
      cap_row  <= cap_row_nxt;
      cap_col  <= cap_col_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    scan_cnt_nxt = scan_cnt;
    deb_cnt_nxt  = deb_cnt;
    col_idx_nxt  = col_idx;
    cap_row_nxt  = cap_row;
    cap_col_nxt  = cap_col;
    apply_key    = 1'b0;
    case (state)
      ST_SCAN: begin
        if (row_s != 4'hF) begin
          state_nxt    = ST_DEB_PRESS;
          cap_col_nxt  = col_idx;
          scan_cnt_nxt = '0;
          deb_cnt_nxt  = '0;
          if (!row_s[0])      cap_row_nxt = 2'd0;
          else if (!row_s[1]) cap_row_nxt = 2'd1;
          else if (!row_s[2]) cap_row_nxt = 2'd2;
          else                cap_row_nxt = 2'd3;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
          scan_cnt_nxt = '0;
          col_idx_nxt  = col_idx + 2'd1;
        end else begin
          scan_cnt_nxt = scan_cnt + 1'b1;
        end
      end
      ST_DEB_PRESS: begin
        if (row_s[cap_row]) begin
          state_nxt   = ST_SCAN;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_nxt   = ST_HELD;
          deb_cnt_nxt = '0;
          apply_key   = 1'b1;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (&row_s) begin
          state_nxt   = ST_DEB_RELEASE;
          deb_cnt_nxt = '0;
        end
      end
      ST_DEB_RELEASE: begin
        if (!(&row_s)) begin
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_nxt   = ST_SCAN;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_SCAN;
    endcase
  end

  keypad_decode u_decode (
    .row      (cap_row),
    .col      (cap_col),
    .key_code (key_code)
  );

  assign col_out     = ~(4'b0001 << col_idx);
  assign acc_x10     = {acc[28:0], 3'b000} + {acc[30:0], 1'b0};
  assign hash_accept = apply_key && (key_code == KEY_HASH) && (digit_count != 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      digit_count <= 4'd0;
      keyboard    <= '0;
      key_valid   <= 1'b0;
    end else begin
      if (apply_key) begin
        if (is_digit(key_code)) begin
          if (digit_count != 4'd9) begin
            acc         <= acc_x10 + {28'd0, key_code};
            digit_count <= digit_count + 4'd1;
          end
        end else if (hash_accept || key_code == KEY_STAR) begin
          acc         <= '0;
          digit_count <= 4'd0;
        end
      end
      if (hash_accept) keyboard <= acc;
      // A commit in the same cycle as ack wins: the new value is still unread.
      if (hash_accept)  key_valid <= 1'b1;
      else if (ack)     key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_input.sv
// Directed bench for keypad_input: a behavioural keypad drives rows from the
// scanned columns, and every result is compared against hand-computed values.
module tb_keypad_input;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_in;
  logic        ack;
  logic [3:0]  col_out;
  logic [31:0] keyboard;
  logic        key_valid;
  logic [3:0]  digit_count;

  logic        kp_pressed;
  logic [1:0]  kp_row, kp_col;
  logic [3:0]  force_low;

  int vectors = 0;
  int errors  = 0;

  keypad_input #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .row_in      (row_in),
    .ack         (ack),
    .col_out     (col_out),
    .keyboard    (keyboard),
    .key_valid   (key_valid),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    if (kp_pressed && !col_out[kp_col]) row_in[kp_row] = 1'b0;
    row_in = row_in & ~force_low;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] key_pos(input byte ch);
    case (ch)
      "1": return 4'b00_00;  "2": return 4'b00_01;  "3": return 4'b00_10;  "A": return 4'b00_11;
      "4": return 4'b01_00;  "5": return 4'b01_01;  "6": return 4'b01_10;  "B": return 4'b01_11;
      "7": return 4'b10_00;  "8": return 4'b10_01;  "9": return 4'b10_10;  "C": return 4'b10_11;
      "*": return 4'b11_00;  "0": return 4'b11_01;  "#": return 4'b11_10;  default: return 4'b11_11;
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Long enough to reach any column and debounce; release long enough to settle.
  task automatic press(input byte ch, input int hold = 40);
    logic [3:0] pos;
    pos = key_pos(ch);
    kp_row = pos[3:2];
    kp_col = pos[1:0];
    kp_pressed = 1'b1;
    cycles(hold);
    kp_pressed = 1'b0;
    cycles(24);
  endtask

  task automatic press_str(input string s);
    for (int i = 0; i < s.len(); i++) press(s[i]);
  endtask

  // Returns at the negedge of the first cycle a column becomes target.
  task automatic wait_col_start(input logic [3:0] target);
    logic [3:0] prev;
    bit         seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      prev = col_out;
      @(negedge clk);
      if (prev != target && col_out == target) seen = 1'b1;
    end
    if (!seen) chk("col_wait", {28'd0, col_out}, {28'd0, target});
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_col;
    logic [3:0] col_before;
    bit         moved;

    reset = 1'b0;
    ack = 1'b0;
    kp_pressed = 1'b0;
    kp_row = 2'd0;
    kp_col = 2'd0;
    force_low = 4'h0;

    cycles(3);
    chk("rst_col", {28'd0, col_out}, 32'hE);
    chk("rst_kb", keyboard, 0);
    chk("rst_valid", {31'd0, key_valid}, 0);
    chk("rst_dc", {28'd0, digit_count}, 0);

    // Idle scan: each column for exactly 4 cycles from reset release.
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      exp_col = 4'hF;
      exp_col[(k / 4) % 4] = 1'b0;
      chk("scan_col", {28'd0, col_out}, {28'd0, exp_col});
      @(negedge clk);
    end
    chk("idle_kb", keyboard, 0);
    chk("idle_valid", {31'd0, key_valid}, 0);

    // 1 2 3 # then ack
    press_str("123");
    chk("dc_123", {28'd0, digit_count}, 3);
    chk("valid_pre_hash", {31'd0, key_valid}, 0);
    press("#");
    chk("kb_123", keyboard, 123);
    chk("valid_123", {31'd0, key_valid}, 1);
    chk("dc_after_hash", {28'd0, digit_count}, 0);
    pulse_ack();
    chk("valid_after_ack", {31'd0, key_valid}, 0);
    chk("kb_after_ack", keyboard, 123);

    // Bounce: row 0 low for only 5 cycles
    wait_col_start(4'b1110);
    force_low = 4'b0001;
    cycles(5);
    force_low = 4'h0;
    cycles(20);
    chk("bounce_dc", {28'd0, digit_count}, 0);
    chk("bounce_kb", keyboard, 123);
    col_before = col_out;
    moved = 1'b0;
    for (int i = 0; i < 8 && !moved; i++) begin
      @(negedge clk);
      if (col_out != col_before) moved = 1'b1;
    end
    chk("bounce_rescan", {31'd0, moved}, 1);

    // Ten 9s: tenth ignored
    press_str("999999999");
    chk("dc_nine", {28'd0, digit_count}, 9);
    press("9");
    chk("dc_tenth", {28'd0, digit_count}, 9);
    press("#");
    chk("kb_9s", keyboard, 999999999);
    chk("valid_9s", {31'd0, key_valid}, 1);

    // Long hold enters one digit; letters are ignored
    press("5", 200);
    chk("dc_hold", {28'd0, digit_count}, 1);
    press_str("ABCD");
    chk("dc_letters", {28'd0, digit_count}, 1);
    press("*");
    chk("dc_star", {28'd0, digit_count}, 0);
    chk("kb_star", keyboard, 999999999);
    chk("valid_star", {31'd0, key_valid}, 1);

    // 4 * 7 # while still valid: overwrite
    press_str("4*7#");
    chk("kb_7", keyboard, 7);
    chk("valid_7", {31'd0, key_valid}, 1);
    pulse_ack();
    chk("valid_7_ack", {31'd0, key_valid}, 0);
    press("#");
    chk("kb_empty_hash", keyboard, 7);
    chk("valid_empty_hash", {31'd0, key_valid}, 0);

    // ack in the exact cycle '#' is accepted: 2 sync + 1 detect + 8 debounce edges
    press("6");
    wait_col_start(4'b1011);
    kp_row = 2'd3;
    kp_col = 2'd2;
    kp_pressed = 1'b1;
    cycles(10);
    chk("valid_before_coinc", {31'd0, key_valid}, 0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("kb_coinc", keyboard, 6);
    chk("valid_coinc", {31'd0, key_valid}, 1);
    @(negedge clk);
    chk("valid_coinc_next", {31'd0, key_valid}, 1);
    kp_pressed = 1'b0;
    cycles(24);

    // Reset in the middle of debouncing key 8
    press("3");
    chk("dc_pre_reset", {28'd0, digit_count}, 1);
    wait_col_start(4'b1101);
    kp_row = 2'd2;
    kp_col = 2'd1;
    kp_pressed = 1'b1;
    cycles(6);
    reset = 1'b0;
    cycles(2);
    kp_pressed = 1'b0;
    cycles(2);
    reset = 1'b1;
    chk("mid_rst_col", {28'd0, col_out}, 32'hE);
    chk("mid_rst_kb", keyboard, 0);
    chk("mid_rst_valid", {31'd0, key_valid}, 0);
    chk("mid_rst_dc", {28'd0, digit_count}, 0);
    cycles(30);
    chk("post_rst_dc", {28'd0, digit_count}, 0);
    chk("post_rst_kb", keyboard, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
